// File: rtl/nios2_debug_action_sequencer.sv
// rtl/nios2_debug_action_sequencer.sv - queues debug take_action strobes and issues them one at a time
//
// Purpose:
//   Captures the one-cycle take_action_* strobes together with the jdo payload.
//   Holds one pending command per action slot and offers the queued commands
//   to the OCI register/memory target one at a time. Each command uses a
//   valid/ready handshake followed by a done pulse.
//   The block flags strobes that hit an already-pending slot, and commands
//   whose done pulse never arrives.
//
// Configuration:
//   NIOS_DBG_SEQ_ROUND_ROBIN_EN - when defined, arbitration is round-robin and
//   starts at a pointer that holds last_grant+1 mod 6. When undefined,
//   arbitration is fixed priority (slot 0 highest) and there is no pointer.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   take_action_*              one-cycle request strobes, slots 0..5
//   jdo                        payload captured in the strobe cycle
//   cmd_valid/code/data        command offered to the target
//   cmd_ready                  target accepts the command (with cmd_valid)
//   cmd_done                   target completion pulse (honoured in WAIT only)
//   err_clr                    clears the sticky error flags
//   pending, busy              per-slot pending bits, activity indicator
//   drop_err, timeout_err      sticky error flags

module nios2_debug_action_sequencer #(
  parameter int JDO_W   = 38,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             take_action_ocimem_a,
  input  logic             take_action_ocimem_b,
  input  logic             take_action_break_a,
  input  logic             take_action_break_b,
  input  logic             take_action_break_c,
  input  logic             take_action_tracectrl,
  input  logic [JDO_W-1:0] jdo,
  output logic             cmd_valid,
  output logic [2:0]       cmd_code,
  output logic [JDO_W-1:0] cmd_data,
  input  logic             cmd_ready,
  input  logic             cmd_done,
  input  logic             err_clr,
  output logic [5:0]       pending,
  output logic             busy,
  output logic             drop_err,
  output logic             timeout_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [5:0]       pending_q, pending_d;
  logic [JDO_W-1:0] slot_q [6];
  logic [JDO_W-1:0] slot_d [6];
  logic             cmd_valid_q, cmd_valid_d;
  logic [2:0]       cmd_code_q, cmd_code_d;
  logic [JDO_W-1:0] cmd_data_q, cmd_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_err_q, drop_err_d;
  logic             timeout_err_q, timeout_err_d;

  logic [5:0]       strobe;
  logic             xfer;
  logic [5:0]       xfer_oh;
  logic             drop_set;
  logic             timeout_set;
  logic [2:0]       winner;
  logic [2:0]       search_base;

  assign strobe = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                   take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};

  // The slot being handed to the target this cycle is free to recapture.
  assign xfer    = (state_q == ST_ISSUE) & cmd_valid_q & cmd_ready;
  assign xfer_oh = xfer ? (6'b000001 << cmd_code_q) : 6'b000000;

`ifdef NIOS_DBG_SEQ_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;

  assign search_base = ptr_q;
  assign ptr_d = xfer ? ((cmd_code_q == 3'd5) ? 3'd0 : cmd_code_q + 3'd1) : ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign search_base = 3'd0;
`endif

  // Search the pending slots starting at search_base, wrapping modulo 6.
  always_comb begin
    logic [3:0] idx;
    logic       found;
    winner = 3'd0;
    found  = 1'b0;
    idx    = 4'd0;
    for (int i = 0; i < 6; i++) begin
      idx = {1'b0, search_base} + 4'(i);
      if (idx >= 4'd6) begin
        idx = idx - 4'd6;
      end
      if (!found && pending_q[idx[2:0]]) begin
        winner = idx[2:0];
        found  = 1'b1;
      end
    end
  end

  // Slot capture. A strobe is accepted when the slot is free, or when the slot
  // is leaving in this very cycle; otherwise the strobe is dropped.
  always_comb begin
    pending_d = pending_q;
    drop_set  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      slot_d[k] = slot_q[k];
      if (xfer_oh[k]) begin
        pending_d[k] = 1'b0;
      end
      if (strobe[k]) begin
        if (!pending_q[k] || xfer_oh[k]) begin
          pending_d[k] = 1'b1;
          slot_d[k]    = jdo;
        end else begin
          drop_set = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_code_d  = cmd_code_q;
    cmd_data_d  = cmd_data_q;
    cnt_d       = cnt_q;
    timeout_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          cmd_code_d  = winner;
          cmd_data_d  = slot_q[winner];
          cmd_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cmd_done) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  // A set event in the same cycle as err_clr wins.
  assign drop_err_d    = drop_set | (drop_err_q & ~err_clr);
  assign timeout_err_d = timeout_set | (timeout_err_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pending_q     <= 6'b000000;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= 3'd0;
      cmd_data_q    <= '0;
      cnt_q         <= '0;
      drop_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      cmd_data_q    <= cmd_data_d;
      cnt_q         <= cnt_d;
      drop_err_q    <= drop_err_d;
      timeout_err_q <= timeout_err_d;
      for (int k = 0; k < 6; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign cmd_data    = cmd_data_q;
  assign pending     = pending_q;
  assign busy        = (state_q != ST_IDLE) | (|pending_q);
  assign drop_err    = drop_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_nios2_debug_action_sequencer.sv
// tb/tb_nios2_debug_action_sequencer.sv - self-checking bench for nios2_debug_action_sequencer

module tb_nios2_debug_action_sequencer;

  localparam int JDO_W   = 38;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             take_action_ocimem_a, take_action_ocimem_b;
  logic             take_action_break_a, take_action_break_b, take_action_break_c;
  logic             take_action_tracectrl;
  logic [JDO_W-1:0] jdo;
  logic             cmd_valid;
  logic [2:0]       cmd_code;
  logic [JDO_W-1:0] cmd_data;
  logic             cmd_ready, cmd_done, err_clr;
  logic [5:0]       pending;
  logic             busy, drop_err, timeout_err;

  int checks = 0;
  int errors = 0;

  logic [40:0] exp_q [$];
  logic [40:0] sb_e;

  always #5 clk = ~clk;

  nios2_debug_action_sequencer #(
    .JDO_W  (JDO_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (8)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .take_action_ocimem_a (take_action_ocimem_a),
    .take_action_ocimem_b (take_action_ocimem_b),
    .take_action_break_a  (take_action_break_a),
    .take_action_break_b  (take_action_break_b),
    .take_action_break_c  (take_action_break_c),
    .take_action_tracectrl(take_action_tracectrl),
    .jdo                  (jdo),
    .cmd_valid            (cmd_valid),
    .cmd_code             (cmd_code),
    .cmd_data             (cmd_data),
    .cmd_ready            (cmd_ready),
    .cmd_done             (cmd_done),
    .err_clr              (err_clr),
    .pending              (pending),
    .busy                 (busy),
    .drop_err             (drop_err),
    .timeout_err          (timeout_err)
  );

  // Scoreboard: every transfer is popped against the next expected command.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: transfer code=%0d data=%h, required no transfer", cmd_code, cmd_data);
      end else begin
        sb_e = exp_q.pop_front();
        if ({cmd_code, cmd_data} !== sb_e) begin
          errors++;
          $display("FAIL sb_transfer: code=%0d data=%h, required code=%0d data=%h",
                   cmd_code, cmd_data, sb_e[40:38], sb_e[37:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_strobes(input logic [5:0] m);
    {take_action_tracectrl, take_action_break_c, take_action_break_b,
     take_action_break_a, take_action_ocimem_b, take_action_ocimem_a} = m;
  endtask

  task automatic pulse(input logic [5:0] m, input logic [JDO_W-1:0] d);
    set_strobes(m);
    jdo = d;
    tick();
    set_strobes(6'b0);
    jdo = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!cmd_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!cmd_valid) begin
      errors++;
      $display("FAIL %s_wait: cmd_valid=0 after %0d cycles, required 1", tag, n);
    end
  endtask

  // Accept the offered command, then complete it one cycle into WAIT.
  task automatic serve(input string tag);
    wait_valid(tag);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_strobes(6'b0);
    jdo = '0;
    cmd_ready = 1'b0;
    cmd_done = 1'b0;
    err_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({cmd_valid, cmd_code, cmd_data, pending, busy, drop_err, timeout_err} !== 50'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b code=%0d data=%h pending=%b busy=%b drop=%b to=%b, required all 0",
               cmd_valid, cmd_code, cmd_data, pending, busy, drop_err, timeout_err);
    end
    tick();
  endtask

  task automatic test_single();
    exp_q.push_back({3'd3, 38'h2A_DEAD_BEEF});
    cmd_ready = 1'b1;
    pulse(6'b001000, 38'h2A_DEAD_BEEF);          // now N+1
    checks++;
    if (pending !== 6'b001000 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_n1: pending=%b valid=%b, required 001000 0", pending, cmd_valid);
    end
    tick();                                       // N+2
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd3 || cmd_data !== 38'h2A_DEAD_BEEF) begin
      errors++;
      $display("FAIL single_n2: valid=%b code=%0d data=%h, required 1 3 2adeadbeef", cmd_valid, cmd_code, cmd_data);
    end
    tick();                                       // N+3
    cmd_ready = 1'b0;
    checks++;
    if (pending[3] !== 1'b0 || cmd_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_n3: pending3=%b valid=%b busy=%b, required 0 0 1", pending[3], cmd_valid, busy);
    end
    tick();                                       // N+4
    tick();                                       // N+5
    cmd_done = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_n5_busy: busy=%b, required 1", busy);
    end
    tick();                                       // N+6
    cmd_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_n6_busy: busy=%b, required 0", busy);
    end
    tick();
  endtask

  task automatic test_contention();
    exp_q.push_back({3'd0, 38'h11});
    pulse(6'b000001, 38'h11);
    serve("cont_prep");
    tick();
`ifdef NIOS_DBG_SEQ_ROUND_ROBIN_EN
    exp_q.push_back({3'd1, 38'h22});
    exp_q.push_back({3'd5, 38'h22});
    exp_q.push_back({3'd0, 38'h22});
`else
    exp_q.push_back({3'd0, 38'h22});
    exp_q.push_back({3'd1, 38'h22});
    exp_q.push_back({3'd5, 38'h22});
`endif
    pulse(6'b100011, 38'h22);
    checks++;
    if (pending !== 6'b100011) begin
      errors++;
      $display("FAIL cont_pending: pending=%b, required 100011", pending);
    end
    for (int i = 0; i < 3; i++) begin
      serve("cont");
      if (i < 2) begin
        checks++;
        if (cmd_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gap%0d: valid=%b, required 0", i, cmd_valid);
        end
        tick();
        checks++;
        if (cmd_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_next%0d: valid=%b, required 1", i, cmd_valid);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL cont_end: busy=%b outstanding=%0d, required 0 0", busy, exp_q.size());
    end
    tick();
  endtask

  task automatic test_backpressure();
    exp_q.push_back({3'd4, 38'h15_1234_5678});
    cmd_ready = 1'b0;
    pulse(6'b010000, 38'h15_1234_5678);
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== 3'd4 || cmd_data !== 38'h15_1234_5678) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b code=%0d data=%h, required 1 4 1512345678", i, cmd_valid, cmd_code, cmd_data);
      end
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || pending[4] !== 1'b0) begin
      errors++;
      $display("FAIL bp_after: valid=%b pending4=%b, required 0 0", cmd_valid, pending[4]);
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    cmd_ready = 1'b0;
    exp_q.push_back({3'd0, 38'h5});
    pulse(6'b000001, 38'h5);
    pulse(6'b000001, 38'h1);                      // dropped, cmd_valid now up
    checks++;
    if (drop_err !== 1'b1 || cmd_data !== 38'h5) begin
      errors++;
      $display("FAIL drop_flag: drop_err=%b data=%h, required 1 5", drop_err, cmd_data);
    end
    // Recapture in the transfer cycle.
    set_strobes(6'b000001);
    jdo = 38'h77;
    cmd_ready = 1'b1;
    tick();
    exp_q.push_back({3'd0, 38'h77});
    set_strobes(6'b0);
    jdo = '0;
    cmd_ready = 1'b0;
    checks++;
    if (pending[0] !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_recap: pending0=%b valid=%b, required 1 0", pending[0], cmd_valid);
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    // Drop and clear in the same cycle: the set wins.
    set_strobes(6'b000001);
    jdo = 38'h99;
    err_clr = 1'b1;
    tick();
    set_strobes(6'b0);
    jdo = '0;
    checks++;
    if (drop_err !== 1'b1) begin
      errors++;
      $display("FAIL drop_set_wins: drop_err=%b, required 1", drop_err);
    end
    tick();
    err_clr = 1'b0;
    checks++;
    if (drop_err !== 1'b0) begin
      errors++;
      $display("FAIL drop_clr: drop_err=%b, required 0", drop_err);
    end
    serve("drop2");
    tick();
  endtask

  task automatic test_timeout();
    exp_q.push_back({3'd1, 38'h0A});
    cmd_ready = 1'b1;
    pulse(6'b000010, 38'h0A);
    wait_valid("to");
    tick();                                       // T: WAIT, count 0
    cmd_ready = 1'b0;
    exp_q.push_back({3'd4, 38'h0B});
    pulse(6'b010000, 38'h0B);                     // T+1
    tick();                                       // T+2
    tick();                                       // T+3
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_early: timeout_err=%b, required 0", timeout_err);
    end
    tick();                                       // T+4
    checks++;
    if (timeout_err !== 1'b1 || cmd_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_set: to=%b valid=%b busy=%b, required 1 0 1", timeout_err, cmd_valid, busy);
    end
    tick();                                       // T+5
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd4) begin
      errors++;
      $display("FAIL to_next: valid=%b code=%0d, required 1 4", cmd_valid, cmd_code);
    end
    serve("to_next");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_clr: timeout_err=%b, required 0", timeout_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    exp_q.push_back({3'd1, 38'h0C});
    cmd_ready = 1'b1;
    pulse(6'b000010, 38'h0C);
    wait_valid("rst");
    tick();                                       // WAIT, count 0
    cmd_ready = 1'b0;
    pulse(6'b010100, 38'h0E);
    checks++;
    if (pending !== 6'b010100) begin
      errors++;
      $display("FAIL rst_pending: pending=%b, required 010100", pending);
    end
    pulse(6'b000100, 38'h0F);
    checks++;
    if (drop_err !== 1'b1) begin
      errors++;
      $display("FAIL rst_drop: drop_err=%b, required 1", drop_err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (pending !== 6'b0 || cmd_valid !== 1'b0 || busy !== 1'b0 || drop_err !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_wait: pending=%b valid=%b busy=%b drop=%b to=%b, required all 0",
               pending, cmd_valid, busy, drop_err, timeout_err);
    end
    tick();
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet: valid=%b busy=%b, required 0 0", cmd_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_drop();
    test_timeout();
    test_reset_mid_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_outstanding: %0d commands never issued, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
